// File: rtl/video_timing_pkg.sv
// video_timing_pkg
// Shared timing constants and types for the chroma sequencing slice:
//   - default per-line clock counts, derived from the system clock period
//   - PAL/NTSC field lengths and vertical-interval burst blanking ranges
//   - seq_state_t, the field/mode state of the sequencer
//   - helpers that pick the field length and burst blanking for a given line
package video_timing_pkg;

  // 48 MHz system clock.
  localparam real CLK_PERIOD_USEC = 1.0 / 48.0;

  // Round-to-nearest conversion of the analogue timings into clock counts.
  localparam int DEF_CLKS_PER_LINE_PAL  = $rtoi(64.0 / CLK_PERIOD_USEC + 0.5);
  localparam int DEF_CLKS_PER_LINE_NTSC = $rtoi(63.556 / CLK_PERIOD_USEC + 0.5);
  localparam int DEF_BURST_START_PAL    = $rtoi(5.6 / CLK_PERIOD_USEC + 0.5);
  localparam int DEF_BURST_START_NTSC   = $rtoi(5.3 / CLK_PERIOD_USEC + 0.5);
  localparam int DEF_HSYNC_LEN          = $rtoi(4.7 / CLK_PERIOD_USEC + 0.5);

  // Counter widths: 12 bits covers a 64 us line at 48 MHz, 10 bits a field.
  localparam int CNT_W  = 12;
  localparam int LINE_W = 10;

  // Lines per field (field 0 / field 1).
  localparam int PAL_F0_LINES  = 313;
  localparam int PAL_F1_LINES  = 312;
  localparam int NTSC_F0_LINES = 263;
  localparam int NTSC_F1_LINES = 262;

  // Burst blanking: head of every field, plus the tail of PAL field 1.
  localparam int PAL_BLANK_HEAD_LAST  = 5;
  localparam int PAL_BLANK_F1_TAIL    = 2;
  localparam int NTSC_BLANK_HEAD_LAST = 8;

  typedef enum logic [1:0] {
    F0          = 2'd0,
    F1          = 2'd1,
    MODE_SWITCH = 2'd2
  } seq_state_t;

  function automatic logic [LINE_W-1:0] field_lines(input logic pal, input logic field1);
    if (pal) return field1 ? LINE_W'(PAL_F1_LINES) : LINE_W'(PAL_F0_LINES);
    return field1 ? LINE_W'(NTSC_F1_LINES) : LINE_W'(NTSC_F0_LINES);
  endfunction

  function automatic logic burst_blanked(input logic pal, input logic field1,
                                         input logic [LINE_W-1:0] line);
    if (pal)
      return (line <= LINE_W'(PAL_BLANK_HEAD_LAST)) ||
             (field1 && (line >= LINE_W'(PAL_F1_LINES - PAL_BLANK_F1_TAIL)));
    return line <= LINE_W'(NTSC_BLANK_HEAD_LAST);
  endfunction

endpackage

// File: rtl/chroma_sequencer_if.sv
// chroma_sequencer_if
// Sequencing bundle between the video generator, the chroma sequencer and
// the QAM modulator.
//   pal_mode_req : requested standard (1 = PAL, 0 = NTSC), from the generator
//   pal_mode     : standard in effect, changes only at frame boundaries
//   hsync        : high for the first HSYNC_LEN clocks of each line
//   startburst   : 1-clock burst start pulse
//   newline      : 1-clock pulse at each line start
//   newframe     : 1-clock pulse at field 0, line 0
//   even_line    : PAL V-switch phase
//   even_field   : 1 during field 0
//   line_num     : 0-based line index within the current field
// master = sequencer side, slave = consumer side.
interface chroma_sequencer_if;
  import video_timing_pkg::*;

  logic              pal_mode_req;
  logic              pal_mode;
  logic              hsync;
  logic              startburst;
  logic              newline;
  logic              newframe;
  logic              even_line;
  logic              even_field;
  logic [LINE_W-1:0] line_num;

  modport master (
    input  pal_mode_req,
    output pal_mode, hsync, startburst, newline, newframe,
           even_line, even_field, line_num
  );

  modport slave (
    output pal_mode_req,
    input  pal_mode, hsync, startburst, newline, newframe,
           even_line, even_field, line_num
  );
endinterface

// File: rtl/line_position_counter.sv
// line_position_counter
// Horizontal clock counter and field-relative line counter.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr         : synchronous clear of both counters (wins over counting)
//   line_len    : clocks per line for the current mode
//   field_len   : lines in the current field
//   h_cnt       : 0..line_len-1
//   line_cnt    : 0..field_len-1
//   line_wrap   : h_cnt is on the last clock of the line
//   field_wrap  : last clock of the last line of the field
module line_position_counter
  import video_timing_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [CNT_W-1:0]  line_len,
  input  logic [LINE_W-1:0] field_len,
  output logic [CNT_W-1:0]  h_cnt,
  output logic [LINE_W-1:0] line_cnt,
  output logic              line_wrap,
  output logic              field_wrap
);

  logic [CNT_W-1:0]  h_cnt_reg;
  logic [LINE_W-1:0] line_cnt_reg;

  assign line_wrap  = (h_cnt_reg == line_len - CNT_W'(1));
  assign field_wrap = line_wrap && (line_cnt_reg == field_len - LINE_W'(1));
  assign h_cnt      = h_cnt_reg;
  assign line_cnt   = line_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_reg    <= '0;
      line_cnt_reg <= '0;
    end else if (clr) begin
      h_cnt_reg    <= '0;
      line_cnt_reg <= '0;
    end else if (line_wrap) begin
      h_cnt_reg    <= '0;
      line_cnt_reg <= field_wrap ? '0 : line_cnt_reg + LINE_W'(1);
    end else begin
      h_cnt_reg    <= h_cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/chroma_sequencer.sv
// chroma_sequencer
// Line/field scheduler for the QAM chroma modulator (interlaced PAL/NTSC).
//   clk    : sole clock
//   rst_n  : asynchronous active-low reset
//   seq    : chroma_sequencer_if.master (pal_mode_req in; pal_mode, hsync,
//            startburst, newline, newframe, even_line, even_field, line_num out)
// A requested standard change is taken only at the field 1 -> field 0 frame
// boundary, through a 1-clock MODE_SWITCH state that lengthens the last line
// of the old frame by one clock.
// Optional feature: define CHROMA_BURST_BLANKING_EN to suppress the burst on
// vertical-interval lines; undefined, a burst is started on every line.
// All outputs are registered decodes of the counters (1 clock lag).
module chroma_sequencer
  import video_timing_pkg::*;
#(
  parameter int CLKS_PER_LINE_PAL  = DEF_CLKS_PER_LINE_PAL,
  parameter int CLKS_PER_LINE_NTSC = DEF_CLKS_PER_LINE_NTSC,
  parameter int BURST_START_PAL    = DEF_BURST_START_PAL,
  parameter int BURST_START_NTSC   = DEF_BURST_START_NTSC,
  parameter int HSYNC_LEN          = DEF_HSYNC_LEN
) (
  input  logic               clk,
  input  logic               rst_n,
  chroma_sequencer_if.master seq
);

  // A burst position past the end of the line is legal but never fires.
  if (BURST_START_PAL >= CLKS_PER_LINE_PAL) begin : g_pal_burst_unreachable
    $warning("chroma_sequencer: BURST_START_PAL beyond line end, PAL burst never fires");
  end
  if (BURST_START_NTSC >= CLKS_PER_LINE_NTSC) begin : g_ntsc_burst_unreachable
    $warning("chroma_sequencer: BURST_START_NTSC beyond line end, NTSC burst never fires");
  end
  if (CLKS_PER_LINE_PAL > 2**CNT_W || CLKS_PER_LINE_NTSC > 2**CNT_W) begin : g_line_too_long
    $error("chroma_sequencer: line length does not fit the horizontal counter");
  end

  seq_state_t        state_reg, state_next;
  logic              mode_reg;      // standard the counters run in
  logic              parity_reg;    // line parity, source of even_line
  logic [CNT_W-1:0]  h_cnt;
  logic [LINE_W-1:0] line_cnt;
  logic              line_wrap, field_wrap;
  logic              in_switch, field1, burst_ok;
  int                burst_start;

  logic              pal_mode_reg, hsync_reg, startburst_reg, newline_reg;
  logic              newframe_reg, even_line_reg, even_field_reg;
  logic [LINE_W-1:0] line_num_reg;
  logic              hsync_next, startburst_next, newline_next, newframe_next;
  logic              even_line_next, even_field_next;
  logic [LINE_W-1:0] line_num_next;

  assign in_switch   = (state_reg == MODE_SWITCH);
  assign field1      = (state_reg == F1);
  assign burst_start = mode_reg ? BURST_START_PAL : BURST_START_NTSC;

`ifdef CHROMA_BURST_BLANKING_EN
  assign burst_ok = !burst_blanked(mode_reg, field1, line_cnt);
`else
  assign burst_ok = 1'b1;
`endif

  line_position_counter u_pos (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (in_switch),
    .line_len   (mode_reg ? CNT_W'(CLKS_PER_LINE_PAL) : CNT_W'(CLKS_PER_LINE_NTSC)),
    .field_len  (field_lines(mode_reg, field1)),
    .h_cnt      (h_cnt),
    .line_cnt   (line_cnt),
    .line_wrap  (line_wrap),
    .field_wrap (field_wrap)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= F0;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      F0:          if (field_wrap) state_next = F1;
      F1:          if (field_wrap) state_next = (seq.pal_mode_req != mode_reg) ? MODE_SWITCH : F0;
      MODE_SWITCH: state_next = F0;
      default:     state_next = F0;
    endcase
  end

  // Mode latch and line parity. MODE_SWITCH is only entered when the request
  // differs from the running mode, so flipping the mode takes the new value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_reg   <= 1'b1;
      parity_reg <= 1'b0;
    end else if (in_switch) begin
      mode_reg   <= ~mode_reg;
      parity_reg <= 1'b0;
    end else if (line_wrap) begin
      parity_reg <= ~parity_reg;
    end
  end

  // Output decode. During the MODE_SWITCH clock nothing pulses and the
  // line/field descriptors hold, so they change together with newline.
  always_comb begin
    newline_next    = !in_switch && (h_cnt == '0);
    newframe_next   = newline_next && (line_cnt == '0) && (state_reg == F0);
    hsync_next      = !in_switch && (int'(h_cnt) < HSYNC_LEN);
    startburst_next = !in_switch && burst_ok && (int'(h_cnt) == burst_start);
    even_field_next = in_switch ? even_field_reg : (state_reg == F0);
    even_line_next  = in_switch ? even_line_reg  : parity_reg;
    line_num_next   = in_switch ? line_num_reg   : line_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pal_mode_reg   <= 1'b1;
      hsync_reg      <= 1'b0;
      startburst_reg <= 1'b0;
      newline_reg    <= 1'b0;
      newframe_reg   <= 1'b0;
      even_line_reg  <= 1'b0;
      even_field_reg <= 1'b1;
      line_num_reg   <= '0;
    end else begin
      pal_mode_reg   <= mode_reg;
      hsync_reg      <= hsync_next;
      startburst_reg <= startburst_next;
      newline_reg    <= newline_next;
      newframe_reg   <= newframe_next;
      even_line_reg  <= even_line_next;
      even_field_reg <= even_field_next;
      line_num_reg   <= line_num_next;
    end
  end

  assign seq.pal_mode   = pal_mode_reg;
  assign seq.hsync      = hsync_reg;
  assign seq.startburst = startburst_reg;
  assign seq.newline    = newline_reg;
  assign seq.newframe   = newframe_reg;
  assign seq.even_line  = even_line_reg;
  assign seq.even_field = even_field_reg;
  assign seq.line_num   = line_num_reg;

endmodule

// File: tb/tb_chroma_sequencer.sv
// tb_chroma_sequencer
// Bench for chroma_sequencer with shortened lines (PAL 24 / NTSC 21 clocks)
// so whole frames fit in a short run. A frame-level reference model (absolute
// frame line + clock within line) predicts every output each clock; a vector
// table and hand-written sequences cover the reset, field, mode-switch and
// burst-blanking corner cases. Honours CHROMA_BURST_BLANKING_EN.
module tb_chroma_sequencer;

  localparam int LP  = 24;
  localparam int LN  = 21;
  localparam int BSP = 9;
  localparam int BSN = 7;
  localparam int HS  = 4;
`ifdef CHROMA_BURST_BLANKING_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  chroma_sequencer_if seq_if ();

  chroma_sequencer #(
    .CLKS_PER_LINE_PAL  (LP),
    .CLKS_PER_LINE_NTSC (LN),
    .BURST_START_PAL    (BSP),
    .BURST_START_NTSC   (BSN),
    .HSYNC_LEN          (HS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .seq   (seq_if)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // ---------------- reference model ----------------
  bit m_mode, m_par, m_extra;
  int m_ln, m_t;
  bit e_pal, e_hs, e_sb, e_nl, e_nf, e_el, e_ef;
  int e_ln;

  function automatic int f0_lines(bit pal); return pal ? 313 : 263; endfunction
  function automatic int f1_lines(bit pal); return pal ? 312 : 262; endfunction
  function automatic int line_clks(bit pal); return pal ? LP : LN; endfunction
  function automatic int burst_pos(bit pal); return pal ? BSP : BSN; endfunction

  function automatic bit burst_allowed(bit pal, int frame_line);
    bit in_f1;
    int loc;
    in_f1 = frame_line >= f0_lines(pal);
    loc = in_f1 ? frame_line - f0_lines(pal) : frame_line;
    if (!BLANK) return 1'b1;
    if (pal) return !(loc <= 5 || (in_f1 && loc >= f1_lines(pal) - 2));
    return loc > 8;
  endfunction

  task automatic model_reset();
    m_ln = 0; m_t = 0; m_mode = 1'b1; m_par = 1'b0; m_extra = 1'b0;
    e_pal = 1'b1; e_hs = 1'b0; e_sb = 1'b0; e_nl = 1'b0; e_nf = 1'b0;
    e_el = 1'b0; e_ef = 1'b1; e_ln = 0;
  endtask

  // Outputs seen after one clock edge, then advance by one clock.
  task automatic model_step(bit req);
    int f0;
    if (m_extra) begin
      // Inserted clock before a new-standard frame: no pulses, hold the rest.
      e_nl = 1'b0; e_nf = 1'b0; e_hs = 1'b0; e_sb = 1'b0;
      m_extra = 1'b0;
      m_mode = ~m_mode;
      return;
    end
    f0 = f0_lines(m_mode);
    e_nl  = (m_t == 0);
    e_nf  = (m_t == 0) && (m_ln == 0);
    e_hs  = (m_t < HS);
    e_sb  = (m_t == burst_pos(m_mode)) && burst_allowed(m_mode, m_ln);
    e_ef  = (m_ln < f0);
    e_ln  = (m_ln < f0) ? m_ln : m_ln - f0;
    e_el  = m_par;
    e_pal = m_mode;
    m_t++;
    if (m_t == line_clks(m_mode)) begin
      m_t = 0;
      m_ln++;
      m_par = ~m_par;
      if (m_ln == f0 + f1_lines(m_mode)) begin
        m_ln = 0;
        if (req != m_mode) begin
          m_extra = 1'b1;
          m_par = 1'b0;
        end
      end
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic summary();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
      if (errors >= 40) summary();
    end
  endtask

  function automatic logic [16:0] dut_vec();
    return {seq_if.pal_mode, seq_if.hsync, seq_if.startburst, seq_if.newline,
            seq_if.newframe, seq_if.even_line, seq_if.even_field, seq_if.line_num};
  endfunction

  function automatic logic [16:0] exp_vec();
    return {e_pal, e_hs, e_sb, e_nl, e_nf, e_el, e_ef, 10'(e_ln)};
  endfunction

  // One clock: sample inputs at the edge, compare all outputs 1 ns later.
  task automatic step();
    bit req_s, rst_s;
    @(posedge clk);
    req_s = seq_if.pal_mode_req;
    rst_s = rst_n;
    cyc++;
    #1;
    if (!rst_s) model_reset();
    else model_step(req_s);
    check("cycle", 32'(dut_vec()), 32'(exp_vec()));
    #1;
  endtask

  // Starting on a newframe clock, walk to the next newframe.
  task automatic measure_frame(input int drop_line, output int lines, output int ef_lines,
                               output int bursts, output int bad_mode, output int first_len,
                               output int last_len, output bit ok);
    bit start_mode;
    int since;
    bit done;
    start_mode = seq_if.pal_mode;
    since = 0; done = 1'b0; ok = 1'b0;
    lines = 1; ef_lines = seq_if.even_field ? 1 : 0;
    bursts = 0; bad_mode = 0; first_len = 0; last_len = 0;
    for (int i = 0; i < 20000 && !done; i++) begin
      step();
      since++;
      if (seq_if.newline && seq_if.newframe) begin
        last_len = since;
        ok = 1'b1;
        done = 1'b1;
      end else begin
        if (seq_if.pal_mode != start_mode) bad_mode++;
        if (seq_if.startburst) bursts++;
        if (seq_if.newline) begin
          if (lines == 1) first_len = since;
          lines++;
          if (seq_if.even_field) ef_lines++;
          since = 0;
          if (drop_line >= 0 && seq_if.even_field && seq_if.line_num == 10'(drop_line))
            seq_if.pal_mode_req = 1'b0;
        end
      end
    end
  endtask

  typedef struct {
    int cyc;
    bit nl, hs, sb, nf, ef, el;
    int ln;
  } vec_t;

  initial begin
    vec_t tbl[12];
    int lines, ef_lines, bursts, bad_mode, first_len, last_len;
    bit ok, found;

    //              cyc    nl    hs    sb      nf    ef    el    ln
    tbl[0]  = '{1,     1'b1, 1'b1, 1'b0,   1'b1, 1'b1, 1'b0, 0};
    tbl[1]  = '{4,     1'b0, 1'b1, 1'b0,   1'b0, 1'b1, 1'b0, 0};
    tbl[2]  = '{5,     1'b0, 1'b0, 1'b0,   1'b0, 1'b1, 1'b0, 0};
    tbl[3]  = '{10,    1'b0, 1'b0, !BLANK, 1'b0, 1'b1, 1'b0, 0};
    tbl[4]  = '{25,    1'b1, 1'b1, 1'b0,   1'b0, 1'b1, 1'b1, 1};
    tbl[5]  = '{49,    1'b1, 1'b1, 1'b0,   1'b0, 1'b1, 1'b0, 2};
    tbl[6]  = '{154,   1'b0, 1'b0, 1'b1,   1'b0, 1'b1, 1'b0, 6};
    tbl[7]  = '{7512,  1'b0, 1'b0, 1'b0,   1'b0, 1'b1, 1'b0, 312};
    tbl[8]  = '{7513,  1'b1, 1'b1, 1'b0,   1'b0, 1'b0, 1'b1, 0};
    tbl[9]  = '{7522,  1'b0, 1'b0, !BLANK, 1'b0, 1'b0, 1'b1, 0};
    tbl[10] = '{14962, 1'b0, 1'b0, !BLANK, 1'b0, 1'b0, 1'b1, 310};
    tbl[11] = '{15001, 1'b1, 1'b1, 1'b0,   1'b1, 1'b1, 1'b1, 0};

    seq_if.pal_mode_req = 1'b1;
    rst_n = 1'b0;
    repeat (3) step();
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;

    for (int i = 0; i < 12; i++) begin
      while (cyc < tbl[i].cyc) step();
      check("vector", 32'({seq_if.newline, seq_if.hsync, seq_if.startburst, seq_if.newframe,
                           seq_if.even_field, seq_if.even_line, seq_if.line_num}),
                      32'({tbl[i].nl, tbl[i].hs, tbl[i].sb, tbl[i].nf, tbl[i].ef,
                           tbl[i].el, 10'(tbl[i].ln)}));
      $display("vector %0d at cycle %0d: nl=%0b sb=%0b el=%0b ef=%0b line=%0d", i, cyc,
               seq_if.newline, seq_if.startburst, seq_if.even_line, seq_if.even_field,
               seq_if.line_num);
    end

    // PAL frame with a request for NTSC dropped at line 100 of field 0.
    measure_frame(100, lines, ef_lines, bursts, bad_mode, first_len, last_len, ok);
    check("pal_frame_done", 32'(ok), 32'(1));
    check("pal_lines", 32'(lines), 32'(625));
    check("pal_even_field_lines", 32'(ef_lines), 32'(313));
    check("pal_bursts", 32'(bursts), BLANK ? 32'(611) : 32'(625));
    check("pal_mode_held", 32'(bad_mode), 32'(0));
    check("pal_first_line_len", 32'(first_len), 32'(LP));
    check("switch_line_len", 32'(last_len), 32'(LP + 1));
    check("mode_at_boundary", 32'(seq_if.pal_mode), 32'(0));
    check("even_line_after_switch", 32'(seq_if.even_line), 32'(0));
    $display("pal frame: lines=%0d field0=%0d bursts=%0d last_len=%0d", lines, ef_lines,
             bursts, last_len);

    // Following NTSC frame, request unchanged.
    measure_frame(-1, lines, ef_lines, bursts, bad_mode, first_len, last_len, ok);
    check("ntsc_frame_done", 32'(ok), 32'(1));
    check("ntsc_lines", 32'(lines), 32'(525));
    check("ntsc_even_field_lines", 32'(ef_lines), 32'(263));
    check("ntsc_bursts", 32'(bursts), BLANK ? 32'(507) : 32'(525));
    check("ntsc_mode_held", 32'(bad_mode), 32'(0));
    check("ntsc_first_line_len", 32'(first_len), 32'(LN));
    check("ntsc_last_line_len", 32'(last_len), 32'(LN));
    $display("ntsc frame: lines=%0d field0=%0d bursts=%0d first_len=%0d", lines, ef_lines,
             bursts, first_len);

    // Random request toggling, checked clock by clock against the model.
    for (int i = 0; i < 12000; i++) begin
      step();
      if ($urandom_range(0, 799) == 0) seq_if.pal_mode_req = ~seq_if.pal_mode_req;
    end
    $display("random phase done at cycle %0d, pal_mode=%0b", cyc, seq_if.pal_mode);

    // Asynchronous reset in the middle of line 200.
    found = 1'b0;
    for (int i = 0; i < 20000 && !found; i++) begin
      step();
      if (seq_if.newline && seq_if.line_num == 10'd200) found = 1'b1;
    end
    check("find_line_200", 32'(found), 32'(1));
    step();
    step();
    #1 rst_n = 1'b0;
    #1;
    check("async_reset", 32'(dut_vec()),
          32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0}));
    repeat (2) step();
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    step();
    check("post_reset_newline", 32'(seq_if.newline), 32'(1));
    check("post_reset_newframe", 32'(seq_if.newframe), 32'(1));
    check("post_reset_line_num", 32'(seq_if.line_num), 32'(0));
    $display("reset mid-line: newline=%0b line=%0d", seq_if.newline, seq_if.line_num);
    repeat (60) step();

    summary();
  end

endmodule
